clken_frac_gen: RTL and testbench
=================================

Name: clken_frac_gen

Overview:
Parametrised multi-channel clock-enable generator. It derives NUM_CH independent fractional-rate enable strobes from the single system clock, using per-channel numerator/denominator accumulators (for example, 11 MHz and 44 MHz rates from 50 MHz). Ratios can be reprogrammed at run time. The block provides a channel-aligned resync and a lock indication that plays the same role as a PLL lock. Cores use it to run logic at derived rates without extra clock domains.

Parameters:
NUM_CH, 2, number of enable channels (1..8)
ACC_W, 16, width of numerator, denominator and accumulator
LOCK_DELAY, 16, quiet cycles after reset/config/resync before locked asserts (>=1)
DEF_NUM, {16'd44,16'd11}, flattened NUM_CH*ACC_W reset numerators; channel k in bits [k*ACC_W +: ACC_W]
DEF_DEN, {16'd50,16'd50}, flattened NUM_CH*ACC_W reset denominators

Ports:
refclk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous and active-high
cfg_we  in  1  single-cycle config write strobe
cfg_ch  in  3  target channel index
cfg_num  in  ACC_W  new numerator
cfg_den  in  ACC_W  new denominator
cfg_err  out  1  one-cycle pulse when a write is rejected
resync  in  1  zero all accumulators (phase-align channels)
ch_run  in  NUM_CH  per-channel run gate
ce_out  out  NUM_CH  enable strobes, registered, one refclk cycle wide
locked  out  1  high once ratios have been stable for LOCK_DELAY cycles

Behaviour:
- Reset (rst=1 at an edge):
  - acc[k]=0, num[k]/den[k] load from DEF_NUM/DEF_DEN.
  - ce_out=0, cfg_err=0, locked=0, lock counter=0.
  - Reset takes priority over every other input.
- Per-channel update, each edge with rst=0 and ch_run[k]=1:
  - Compute sum = acc[k] + num[k] at ACC_W+1 bits (no wrap).
  - If sum >= den[k]: acc[k] <= sum - den[k] and ce_out[k] <= 1.
  - Otherwise: acc[k] <= sum and ce_out[k] <= 0.
- Output latency is 1 cycle from the accumulator decision (registered output).
- ch_run[k]=0: acc[k] holds and ce_out[k] <= 0. Resuming continues from the held acc.
- Rate rules:
  - Over any den[k] consecutive running cycles, exactly num[k] ce pulses occur.
  - num=den gives ce every cycle.
  - num=0 gives ce never.
- Config write (cfg_we=1):
  - Valid only if cfg_ch < NUM_CH, cfg_den != 0 and cfg_num <= cfg_den.
  - Valid write: at that edge num/den[cfg_ch] update, acc[cfg_ch] <= 0, ce_out[cfg_ch] <= 0. New ratio is used from the next edge.
  - Invalid write: no state change, cfg_err <= 1 for one cycle.
- resync=1: all acc <= 0 and all ce_out <= 0 at that edge. Channels then run phase-aligned.
- Simultaneous cfg_we and resync: both apply. The written channel gets its new ratio and all accumulators zero.
- Lock counter:
  - Cleared (locked <= 0) by rst, resync, or a valid cfg write.
  - Otherwise increments, saturating at LOCK_DELAY.
  - locked <= 1 when the counter reaches LOCK_DELAY.
  - Invalid writes do not affect the counter or locked.
- ch_run does not affect locked.
- locked is informational only; ce_out runs regardless of locked.

Test Plan:
- Defaults, ch_run=11b, release rst:
  - ch0 (11/50): first ce_out[0] after the 5th edge; exactly 11 pulses per 50 cycles, repeating.
  - ch1 (44/50): 44 pulses per 50 cycles.
  - locked rises after the 16th edge post-reset.
- Valid write ch0 num=1 den=4 mid-run: ce_out[0] pulses every 4th cycle starting 4 edges after the write; locked drops and re-asserts 16 cycles later.
- Invalid writes (den=0; num=5 den=3; cfg_ch=2 with NUM_CH=2): cfg_err single pulse each; ratios, accumulators and locked unchanged.
- resync during operation, both channels set to 1/2: after resync, ce_out[0] and ce_out[1] pulse on identical cycles; locked drops for 16 cycles.
- Gating: ch_run[1]=0 for 7 cycles gives ce_out[1]=0 throughout; on resume the pulse count over the next 50 running cycles is exactly 44.
- Reset mid-run with a pending config write on the same edge: reset wins. Default ratios restore, ce_out=0, cfg_err=0, locked=0.

Source files
------------

// File: rtl/clken_frac_gen.sv
// clken_frac_gen: NUM_CH fractional-rate clock-enable strobes from one clock.
// Ports: refclk, rst (sync, active-high), cfg_we/cfg_ch/cfg_num/cfg_den,
// cfg_err, resync, ch_run[NUM_CH], ce_out[NUM_CH], locked.
module clken_frac_gen #(
    parameter int NUM_CH     = 2,
    parameter int ACC_W      = 16,
    parameter int LOCK_DELAY = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = {16'd44, 16'd11},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = {16'd50, 16'd50}
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_err,
    input  logic              resync,
    input  logic [NUM_CH-1:0] ch_run,
    output logic [NUM_CH-1:0] ce_out,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_DELAY + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_DELAY);

    logic [ACC_W-1:0] num_q  [NUM_CH];
    logic [ACC_W-1:0] den_q  [NUM_CH];
    logic [ACC_W-1:0] acc_q  [NUM_CH];
    logic [ACC_W-1:0] acc_nx [NUM_CH];
    logic [ACC_W:0]   sum    [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] wr_sel;
    logic              cfg_ok;
    logic [CNT_W-1:0]  lock_cnt;
    logic [CNT_W-1:0]  lock_nx;

    always_comb begin
        cfg_ok = cfg_we
              && ({29'd0, cfg_ch} < 32'(NUM_CH))
              && (cfg_den != '0)
              && (cfg_num <= cfg_den);
        hit    = '0;
        wr_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // Compare at ACC_W+1 bits so acc+num never wraps before the test.
            sum[k]    = {1'b0, acc_q[k]} + {1'b0, num_q[k]};
            hit[k]    = sum[k] >= {1'b0, den_q[k]};
            // Modular ACC_W arithmetic is exact here: the true result fits.
            acc_nx[k] = hit[k] ? (acc_q[k] + num_q[k] - den_q[k])
                               : (acc_q[k] + num_q[k]);
            wr_sel[k] = cfg_ok && (cfg_ch == 3'(k));
        end
        lock_nx = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                num_q[k] <= DEF_NUM[k*ACC_W +: ACC_W];
                den_q[k] <= DEF_DEN[k*ACC_W +: ACC_W];
                acc_q[k] <= '0;
            end
            ce_out   <= '0;
            cfg_err  <= 1'b0;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_sel[k]) begin
                    num_q[k] <= cfg_num;
                    den_q[k] <= cfg_den;
                end
                // Write and resync both restart the phase; they may coincide.
                if (wr_sel[k] || resync) begin
                    acc_q[k]  <= '0;
                    ce_out[k] <= 1'b0;
                end else if (ch_run[k]) begin
                    acc_q[k]  <= acc_nx[k];
                    ce_out[k] <= hit[k];
                end else begin
                    ce_out[k] <= 1'b0;
                end
            end
            if (resync || cfg_ok) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                lock_cnt <= lock_nx;
                locked   <= (lock_nx == LOCK_MAX);
            end
        end
    end

endmodule

// File: tb/tb_clken_frac_gen.sv
// tb_clken_frac_gen: directed bench for clken_frac_gen (2 channels, defaults).
// Drives stimulus 1 time unit after each rising edge and samples there too.
module tb_clken_frac_gen;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic        cfg_err;
    logic        resync;
    logic [1:0]  ch_run;
    logic [1:0]  ce_out;
    logic        locked;

    int n_chk  = 0;
    int n_fail = 0;

    int          c0, c1, first;
    logic        l15, l16, g1;
    logic [11:0] pat;
    logic [7:0]  p0, p1;

    clken_frac_gen dut (
        .refclk  (refclk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_num (cfg_num),
        .cfg_den (cfg_den),
        .cfg_err (cfg_err),
        .resync  (resync),
        .ch_run  (ch_run),
        .ce_out  (ce_out),
        .locked  (locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [15:0] n,
                             input logic [15:0] d);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_num = n;
        cfg_den = d;
        tick();
        cfg_we  = 1'b0;
    endtask

    // Runs n edges, counting pulses per channel, first ch0 pulse edge
    // and locked after edges 15 and 16.
    task automatic run_win(input int n, output int k0, output int k1,
                           output int f0, output logic q15,
                           output logic q16);
        k0 = 0; k1 = 0; f0 = -1; q15 = 1'bx; q16 = 1'bx;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (ce_out[0] && f0 < 0) f0 = i;
            k0 += int'(ce_out[0]);
            k1 += int'(ce_out[1]);
            if (i == 15) q15 = locked;
            if (i == 16) q16 = locked;
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
        cfg_num = '0; cfg_den = '0; resync = 1'b0; ch_run = 2'b11;
        tick(); tick();
        chk("rst_ce", 32'(ce_out), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);

        // Default ratios 11/50 and 44/50.
        rst = 1'b0;
        run_win(50, c0, c1, first, l15, l16);
        chk("def_ch0_first", first, 5);
        chk("def_ch0_cnt", c0, 11);
        chk("def_ch1_cnt", c1, 44);
        chk("def_lock_e15", 32'(l15), 0);
        chk("def_lock_e16", 32'(l16), 1);
        run_win(50, c0, c1, first, l15, l16);
        chk("def_ch0_cnt2", c0, 11);
        chk("def_ch1_cnt2", c1, 44);

        // Valid write ch0 = 1/4.
        cfg_write(3'd0, 16'd1, 16'd4);
        chk("wr_ce0", 32'(ce_out[0]), 0);
        chk("wr_locked", 32'(locked), 0);
        chk("wr_cfg_err", 32'(cfg_err), 0);
        pat = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i <= 12) pat[i-1] = ce_out[0];
            if (i == 15) l15 = locked;
            if (i == 16) l16 = locked;
        end
        chk("wr_pat", 32'(pat), 32'h888);
        chk("wr_lock_e15", 32'(l15), 0);
        chk("wr_lock_e16", 32'(l16), 1);

        // Invalid writes: den=0, num>den, channel out of range.
        cfg_write(3'd0, 16'd3, 16'd0);
        chk("inv_den0_err", 32'(cfg_err), 1);
        chk("inv_den0_lock", 32'(locked), 1);
        tick();
        chk("inv_den0_err_off", 32'(cfg_err), 0);
        cfg_write(3'd0, 16'd5, 16'd3);
        chk("inv_big_err", 32'(cfg_err), 1);
        chk("inv_big_lock", 32'(locked), 1);
        tick();
        chk("inv_big_err_off", 32'(cfg_err), 0);
        cfg_write(3'd2, 16'd1, 16'd2);
        chk("inv_ch_err", 32'(cfg_err), 1);
        chk("inv_ch_lock", 32'(locked), 1);
        tick();
        chk("inv_ch_err_off", 32'(cfg_err), 0);
        // acc0 is 2 here if untouched: pulses on 2nd and 6th edges.
        p0 = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            p0[i-1] = ce_out[0];
        end
        chk("inv_pat", 32'(p0), 32'h22);
        chk("inv_lock_after", 32'(locked), 1);

        // Both channels 1/2, deliberately out of phase, then resync.
        cfg_write(3'd0, 16'd1, 16'd2);
        cfg_write(3'd1, 16'd1, 16'd2);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        chk("rs_ce", 32'(ce_out), 0);
        chk("rs_locked", 32'(locked), 0);
        p0 = '0; p1 = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i <= 8) begin
                p0[i-1] = ce_out[0];
                p1[i-1] = ce_out[1];
            end
            if (i == 15) l15 = locked;
            if (i == 16) l16 = locked;
        end
        chk("rs_pat0", 32'(p0), 32'hAA);
        chk("rs_pat1", 32'(p1), 32'hAA);
        chk("rs_lock_e15", 32'(l15), 0);
        chk("rs_lock_e16", 32'(l16), 1);

        // Gating ch1 at 44/50 for 7 cycles with a nonzero held accumulator.
        cfg_write(3'd1, 16'd44, 16'd50);
        tick(); tick(); tick();
        ch_run = 2'b01;
        g1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            g1 |= ce_out[1];
        end
        chk("gate_ce1", 32'(g1), 0);
        ch_run = 2'b11;
        run_win(50, c0, c1, first, l15, l16);
        chk("gate_resume_cnt", c1, 44);

        // Reset beats a coincident invalid, then a valid, config write.
        rst = 1'b1;
        cfg_write(3'd0, 16'd3, 16'd0);
        chk("rstw_inv_err", 32'(cfg_err), 0);
        chk("rstw_inv_ce", 32'(ce_out), 0);
        cfg_write(3'd0, 16'd3, 16'd7);
        chk("rstw_ce", 32'(ce_out), 0);
        chk("rstw_err", 32'(cfg_err), 0);
        chk("rstw_locked", 32'(locked), 0);
        rst = 1'b0;
        run_win(50, c0, c1, first, l15, l16);
        chk("rstw_ch0_first", first, 5);
        chk("rstw_ch0_cnt", c0, 11);
        chk("rstw_ch1_cnt", c1, 44);
        chk("rstw_lock_e15", 32'(l15), 0);
        chk("rstw_lock_e16", 32'(l16), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
